// File: rtl/uart_fifo_core.sv
// Memory-mapped UART peripheral: TX/RX shift engines with independent FIFOs,
// runtime baud divisor, sticky error flags and level interrupts.
module uart_fifo_core #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned CLK_DIV    = 15
) (
    input  logic        g_clk,
    input  logic        g_reset,
    output logic        g_clk_req,
    input  logic        uart_rx,
    output logic        uart_tx,
    input  logic        mem_req,
    output logic        mem_gnt,
    input  logic        mem_wen,
    input  logic [3:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_rsp,
    output logic        mem_error,
    output logic        irq_rx,
    output logic        irq_tx
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned BW = 4;
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(3);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [1:0] sel;
    logic       bus_rd, bus_wr, stat_rd;
    logic [DIV_W-1:0] div;
    logic       overrun, frame_err;
    logic       unused_ok;

    assign sel       = mem_addr[3:2];
    assign bus_rd    = mem_req & ~mem_wen;
    assign bus_wr    = mem_req & mem_wen;
    assign stat_rd   = bus_rd && (sel == 2'd2);
    assign mem_gnt   = 1'b1;
    assign unused_ok = ^{mem_addr[1:0], mem_wdata[31:DIV_W]};

    // TX FIFO: bus pushes, TX engine pops
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wp, tx_rp;
    logic tx_empty, tx_full, tx_push, tx_pop;
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW-1:0] == tx_rp[AW-1:0]) && (tx_wp[AW] != tx_rp[AW]);
    assign tx_push  = bus_wr && (sel == 2'd1) && (!tx_full || tx_pop);

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + PW'(1);
        end
    end

    always_ff @(posedge g_clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= mem_wdata[DATA_BITS-1:0];
    end

    // RX FIFO: RX engine pushes, bus pops
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wp, rx_rp;
    logic rx_empty, rx_full, rx_push, rx_push_req, rx_pop;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW-1:0] == rx_rp[AW-1:0]) && (rx_wp[AW] != rx_rp[AW]);
    assign rx_pop   = bus_rd && (sel == 2'd0) && !rx_empty;
    assign rx_push  = rx_push_req && (!rx_full || rx_pop);

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + PW'(1);
            if (rx_pop)  rx_rp <= rx_rp + PW'(1);
        end
    end

    always_ff @(posedge g_clk) begin
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    // TX engine
    state_t tx_state, tx_state_n;
    logic [DIV_W-1:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
    logic [BW-1:0] tx_bit, tx_bit_n;
    logic tx_out, tx_out_n, tx_load, tx_busy;
    assign tx_busy = (tx_state != S_IDLE);
    assign uart_tx = tx_out;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_sh    <= '0;
            tx_bit   <= '0;
            tx_out   <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_sh    <= tx_sh_n;
            tx_bit   <= tx_bit_n;
            tx_out   <= tx_out_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_div_n   = tx_div;
        tx_sh_n    = tx_sh;
        tx_bit_n   = tx_bit;
        tx_out_n   = tx_out;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_out_n = 1'b1;
                tx_load  = !tx_empty;
            end
            S_START: begin
                if (tx_cnt == '0) begin
                    tx_state_n = S_DATA;
                    tx_cnt_n   = tx_div;
                    tx_out_n   = tx_sh[0];
                    tx_sh_n    = tx_sh >> 1;
                    tx_bit_n   = '0;
                end else begin
                    tx_cnt_n = tx_cnt - DIV_W'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n = tx_div;
                    if (tx_bit == BW'(DATA_BITS - 1)) begin
                        tx_state_n = S_STOP;
                        tx_out_n   = 1'b1;
                    end else begin
                        tx_bit_n = tx_bit + BW'(1);
                        tx_out_n = tx_sh[0];
                        tx_sh_n  = tx_sh >> 1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt - DIV_W'(1);
                end
            end
            default: begin
                if (tx_cnt == '0) begin
                    tx_state_n = S_IDLE;
                    tx_load    = !tx_empty;
                end else begin
                    tx_cnt_n = tx_cnt - DIV_W'(1);
                end
            end
        endcase
        // Frame start: divisor is latched here so DIV writes apply per frame
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_n = S_START;
            tx_cnt_n   = div;
            tx_div_n   = div;
            tx_sh_n    = tx_mem[tx_rp[AW-1:0]];
            tx_out_n   = 1'b0;
        end
    end

    // RX engine
    logic rx_s1, rx_s2, rx_s3, rx_fall, ferr_set, rx_busy;
    state_t rx_state, rx_state_n;
    logic [DIV_W-1:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [DIV_W:0] rx_half;
    logic [BW-1:0] rx_bit, rx_bit_n;
    assign rx_fall = rx_s3 & ~rx_s2;
    assign rx_busy = (rx_state != S_IDLE);
    assign rx_half = ({1'b0, div} + (DIV_W + 1)'(1)) >> 1;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= '0;
            rx_sh    <= '0;
            rx_bit   <= '0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_sh    <= rx_sh_n;
            rx_bit   <= rx_bit_n;
        end
    end

    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_div_n    = rx_div;
        rx_sh_n     = rx_sh;
        rx_bit_n    = rx_bit;
        rx_push_req = 1'b0;
        ferr_set    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_state_n = S_START;
                    rx_div_n   = div;
                    rx_cnt_n   = DIV_W'(rx_half - (DIV_W + 1)'(1));
                end
            end
            S_START: begin
                if (rx_cnt == '0) begin
                    rx_state_n = rx_s2 ? S_IDLE : S_DATA;
                    rx_cnt_n   = rx_div;
                    rx_bit_n   = '0;
                end else begin
                    rx_cnt_n = rx_cnt - DIV_W'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt == '0) begin
                    rx_sh_n  = {rx_s2, rx_sh[DATA_BITS-1:1]};
                    rx_cnt_n = rx_div;
                    rx_bit_n = rx_bit + BW'(1);
                    if (rx_bit == BW'(DATA_BITS - 1)) rx_state_n = S_STOP;
                end else begin
                    rx_cnt_n = rx_cnt - DIV_W'(1);
                end
            end
            default: begin
                if (rx_cnt == '0) begin
                    rx_state_n  = S_IDLE;
                    rx_push_req = rx_s2;
                    ferr_set    = ~rx_s2;
                end else begin
                    rx_cnt_n = rx_cnt - DIV_W'(1);
                end
            end
        endcase
    end

    // Registers, sticky flags and bus response
    logic [6:0]  stat_c;
    logic [31:0] rd_c;
    logic        err_c;
    assign stat_c = {tx_busy, frame_err, overrun, tx_full, tx_empty, rx_full, ~rx_empty};

    always_comb begin
        rd_c  = '0;
        err_c = 1'b0;
        case (sel)
            2'd0: begin
                if (mem_wen)        err_c = 1'b1;
                else if (!rx_empty) rd_c  = 32'(rx_mem[rx_rp[AW-1:0]]);
            end
            2'd1:    err_c = mem_wen & ~tx_push;
            2'd2: begin
                if (mem_wen) err_c = 1'b1;
                else         rd_c  = 32'(stat_c);
            end
            default: rd_c = 32'(div);
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            div       <= DIV_W'(CLK_DIV);
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            mem_rsp   <= 1'b0;
            mem_error <= 1'b0;
            mem_rdata <= '0;
        end else begin
            if (bus_wr && (sel == 2'd3))
                div <= (mem_wdata[DIV_W-1:0] < DIV_MIN) ? DIV_MIN : mem_wdata[DIV_W-1:0];
            overrun   <= (overrun & ~stat_rd) | (rx_push_req & ~rx_push);
            frame_err <= (frame_err & ~stat_rd) | ferr_set;
            mem_rsp   <= mem_req;
            mem_error <= mem_req & err_c;
            mem_rdata <= bus_rd ? rd_c : '0;
        end
    end

    assign irq_rx    = ~rx_empty;
    assign irq_tx    = tx_empty;
    assign g_clk_req = mem_req | mem_rsp | tx_busy | ~tx_empty | rx_busy | ~rx_empty;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core: bus responses and serial TX frames are
// queued as expectations at stimulus time and checked by independent monitors.
module tb_uart_fifo_core;
    logic        g_clk = 1'b0;
    logic        g_reset, g_clk_req, uart_rx, uart_tx;
    logic        mem_req, mem_gnt, mem_wen, mem_rsp, mem_error, irq_rx, irq_tx;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    bit tx_mon_en = 1'b1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        string       name;
    } rsp_t;
    rsp_t       rspq[$];
    logic [7:0] txq[$];

    uart_fifo_core dut (
        .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(g_clk_req),
        .uart_rx(uart_rx), .uart_tx(uart_tx),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rsp(mem_rsp), .mem_error(mem_error),
        .irq_rx(irq_rx), .irq_tx(irq_tx)
    );

    always #5 g_clk = ~g_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge g_clk);
        #1;
    endtask

    // One bus transfer; expectation queued before the DUT can respond
    task automatic bus(input logic wen, input logic [3:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input string name);
        rsp_t r;
        r.rdata = exp_rd; r.err = exp_err; r.chk_rd = ~wen; r.name = name;
        rspq.push_back(r);
        mem_req = 1'b1; mem_wen = wen; mem_addr = addr; mem_wdata = wdata;
        @(posedge g_clk); #1;
        mem_req = 1'b0; mem_wen = 1'b0;
    endtask

    // Serial frame on uart_rx at 16 cycles per bit
    task automatic send_frame(input logic [7:0] d, input logic stop);
        uart_rx = 1'b0; cyc(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i]; cyc(16);
        end
        uart_rx = stop; cyc(16);
        uart_rx = 1'b1; cyc(4);
    endtask

    task automatic wait_quiet(input int maxc, input string name);
        int n = 0;
        while (g_clk_req && n < maxc) begin
            cyc(1);
            n++;
        end
        check(name, 32'(g_clk_req), 32'(0));
    endtask

    always @(negedge g_clk) begin
        if (mem_rsp) begin
            rsp_t r;
            if (rspq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp: got rsp with no pending request expected none");
            end else begin
                r = rspq.pop_front();
                if (r.chk_rd) check({r.name, "_rdata"}, mem_rdata, r.rdata);
                check({r.name, "_err"}, 32'(mem_error), 32'(r.err));
            end
        end
    end

    // Decodes frames on uart_tx (DIV=15) and compares with queued bytes
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            if (tx_mon_en) begin
                repeat (8) @(negedge g_clk);
                check("tx_start_bit", 32'(uart_tx), 32'(0));
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge g_clk);
                    b[i] = uart_tx;
                end
                repeat (16) @(negedge g_clk);
                check("tx_stop_bit", 32'(uart_tx), 32'(1));
                if (txq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected_frame: got 0x%0h expected no frame", b);
                end else begin
                    check("tx_frame", 32'(b), 32'(txq.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a5;
        logic       exp_bit, bad;
        a5 = 8'hA5;
        g_reset = 1'b1; uart_rx = 1'b1;
        mem_req = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0;
        cyc(3);
        g_reset = 1'b0;

        // Reset state
        check("rst_uart_tx", 32'(uart_tx), 32'(1));
        check("rst_mem_rsp", 32'(mem_rsp), 32'(0));
        check("rst_mem_err", 32'(mem_error), 32'(0));
        check("rst_mem_rdata", mem_rdata, 32'(0));
        check("rst_irq_tx", 32'(irq_tx), 32'(1));
        check("rst_irq_rx", 32'(irq_rx), 32'(0));
        check("rst_clk_req", 32'(g_clk_req), 32'(0));
        check("mem_gnt", 32'(mem_gnt), 32'(1));
        bus(1'b0, 4'h8, 0, 32'h04, 1'b0, "stat_reset");
        bus(1'b0, 4'hC, 0, 32'd15, 1'b0, "div_reset");
        cyc(2);

        // TX of 0xA5: 16-cycle start, LSB-first data, 16-cycle stop
        bus(1'b1, 4'h4, 32'hA5, 0, 1'b0, "txd_a5");
        txq.push_back(8'hA5);
        check("irq_tx_push", 32'(irq_tx), 32'(0));
        bad = 1'b0;
        for (int i = 0; i < 160; i++) begin
            cyc(1);
            if (i == 0) check("irq_tx_pop", 32'(irq_tx), 32'(1));
            if (i < 16)       exp_bit = 1'b0;
            else if (i < 144) exp_bit = a5[(i / 16) - 1];
            else              exp_bit = 1'b1;
            if (uart_tx !== exp_bit) bad = 1'b1;
            if (i % 16 == 15) begin
                check($sformatf("tx_a5_seg%0d_bad", i / 16), 32'(bad), 32'(0));
                bad = 1'b0;
            end
        end
        check("clk_req_stop_bit", 32'(g_clk_req), 32'(1));
        cyc(1);
        check("clk_req_idle", 32'(g_clk_req), 32'(0));
        bus(1'b0, 4'h8, 0, 32'h04, 1'b0, "stat_tx_idle");

        // Five back-to-back writes fill shifter + FIFO, sixth is dropped
        for (int k = 0; k < 5; k++) begin
            bus(1'b1, 4'h4, 32'(17 * (k + 1)), 0, 1'b0, $sformatf("txd_q%0d", k));
            txq.push_back(8'(17 * (k + 1)));
        end
        bus(1'b1, 4'h4, 32'h66, 0, 1'b1, "txd_full");
        bus(1'b0, 4'h8, 0, 32'h48, 1'b0, "stat_tx_full");
        wait_quiet(2000, "tx_drain");
        cyc(4);
        check("txq_empty", 32'(txq.size()), 32'(0));

        // Single RX frame
        send_frame(8'h3C, 1'b1);
        check("irq_rx_set", 32'(irq_rx), 32'(1));
        bus(1'b0, 4'h0, 0, 32'h3C, 1'b0, "rxd_3c");
        bus(1'b0, 4'h0, 0, 32'h00, 1'b0, "rxd_empty");
        bus(1'b1, 4'h0, 32'h99, 0, 1'b1, "rxd_write");
        check("irq_rx_clear", 32'(irq_rx), 32'(0));

        // Five frames into a 4-deep FIFO: overrun, cleared on STAT read
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
        bus(1'b0, 4'h8, 0, 32'h17, 1'b0, "stat_overrun");
        bus(1'b0, 4'h8, 0, 32'h07, 1'b0, "stat_ovr_cleared");
        for (int k = 1; k <= 4; k++) bus(1'b0, 4'h0, 0, 32'(k), 1'b0, $sformatf("rxd_q%0d", k));
        bus(1'b0, 4'h0, 0, 32'h00, 1'b0, "rxd_drained");

        // Bad stop bit, then a short glitch, then a clean frame
        send_frame(8'h5A, 1'b0);
        check("irq_rx_ferr", 32'(irq_rx), 32'(0));
        bus(1'b0, 4'h8, 0, 32'h24, 1'b0, "stat_frame_err");
        bus(1'b0, 4'h8, 0, 32'h04, 1'b0, "stat_ferr_cleared");
        uart_rx = 1'b0; cyc(4);
        uart_rx = 1'b1; cyc(30);
        bus(1'b0, 4'h8, 0, 32'h04, 1'b0, "stat_glitch");
        check("irq_rx_glitch", 32'(irq_rx), 32'(0));
        send_frame(8'hC3, 1'b1);
        bus(1'b0, 4'h0, 0, 32'hC3, 1'b0, "rxd_c3");

        // DIV clamp, read/write side cases
        bus(1'b1, 4'hC, 32'd1, 0, 1'b0, "div_wr1");
        bus(1'b0, 4'hC, 0, 32'd3, 1'b0, "div_clamp");
        bus(1'b1, 4'hC, 32'h20, 0, 1'b0, "div_wr20");
        bus(1'b0, 4'hC, 0, 32'h20, 1'b0, "div_rd20");
        bus(1'b0, 4'h4, 0, 32'h0, 1'b0, "txd_read");
        bus(1'b1, 4'h8, 32'h7F, 0, 1'b1, "stat_write");

        // Reset mid-frame aborts TX and restores DIV
        tx_mon_en = 1'b0;
        bus(1'b1, 4'hC, 32'd7, 0, 1'b0, "div_wr7");
        bus(1'b1, 4'h4, 32'h00, 0, 1'b0, "txd_00");
        cyc(40);
        check("tx_mid_frame", 32'(uart_tx), 32'(0));
        g_reset = 1'b1;
        cyc(1);
        check("tx_after_reset", 32'(uart_tx), 32'(1));
        check("irq_tx_after_reset", 32'(irq_tx), 32'(1));
        g_reset = 1'b0;
        cyc(1);
        bus(1'b0, 4'hC, 0, 32'd15, 1'b0, "div_after_reset");
        bus(1'b0, 4'h8, 0, 32'h04, 1'b0, "stat_after_reset");
        cyc(3);
        check("rspq_empty", 32'(rspq.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
